apot4_dot_seq: RTL and testbench

APOT4_DOT_SEQ -- requirements
Module: apot4_dot_seq

---
 rtl/apot4_dot_seq.sv | 170 +++++++++++++++++
 tb/tb_apot4_dot_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apot4_dot_seq.sv
// apot4_dot_seq: sequencer for an APoT4 dot product on an external MAC.
// A job reads cfg_len element pairs from the activation and weight buffers.
// It streams each pair into the MAC one cycle after the read.
// It then waits for the MAC pipeline to drain and presents the accumulator value.
// Job latency is fixed: 1 + len + MAC_LAT + 1 + 1 cycles from start to res_valid.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start_valid / start_ready   job request handshake
//   cfg_len, cfg_act_base,
//   cfg_wgt_base                element count and buffer base addresses
//   act_rd_en/addr/data,
//   wgt_rd_en/addr/data         buffer reads (data valid one cycle after rd_en)
//   mac_clr, mac_en,
//   mac_act, mac_weight         MAC control and operands
//   mac_out                     MAC accumulator value
//   res_valid/res_ready,
//   res_data                    result handshake
//   busy                        high whenever a job is in progress
module apot4_dot_seq #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned MAC_LAT    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [ADDR_WIDTH-1:0]       cfg_len,
    input  logic [ADDR_WIDTH-1:0]       cfg_act_base,
    input  logic [ADDR_WIDTH-1:0]       cfg_wgt_base,
    output logic                        act_rd_en,
    output logic [ADDR_WIDTH-1:0]       act_rd_addr,
    input  logic [3:0]                  act_rd_data,
    output logic                        wgt_rd_en,
    output logic [ADDR_WIDTH-1:0]       wgt_rd_addr,
    input  logic [3:0]                  wgt_rd_data,
    output logic                        mac_clr,
    output logic                        mac_en,
    output logic [3:0]                  mac_act,
    output logic [3:0]                  mac_weight,
    input  logic signed [ACC_WIDTH-1:0] mac_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic signed [ACC_WIDTH-1:0] res_data,
    output logic                        busy
);

    // Drain counter must hold values 0..MAC_LAT.
    localparam int unsigned DRAIN_W = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [ADDR_WIDTH-1:0]         len_q;
    logic [ADDR_WIDTH-1:0]         act_base_q;
    logic [ADDR_WIDTH-1:0]         wgt_base_q;
    logic [ADDR_WIDTH-1:0]         idx_q;
    logic [DRAIN_W-1:0]            drain_q;
    logic                          mac_en_q;
    logic signed [ACC_WIDTH-1:0]   res_q;

    logic load_cfg;
    logic job_clr;
    logic issue;
    logic drain_inc;
    logic capture;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            act_base_q <= '0;
            wgt_base_q <= '0;
            idx_q      <= '0;
            drain_q    <= '0;
            mac_en_q   <= 1'b0;
            res_q      <= '0;
        end else begin
            state    <= state_next;
            mac_en_q <= issue;
            if (load_cfg) begin
                len_q      <= cfg_len;
                act_base_q <= cfg_act_base;
                wgt_base_q <= cfg_wgt_base;
            end
            if (job_clr) begin
                idx_q   <= '0;
                drain_q <= '0;
            end
            if (issue) begin
                idx_q <= idx_q + ADDR_WIDTH'(1);
            end
            if (drain_inc) begin
                drain_q <= drain_q + DRAIN_W'(1);
            end
            if (capture) begin
                res_q <= mac_out;
            end
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_next = state;
        load_cfg   = 1'b0;
        job_clr    = 1'b0;
        issue      = 1'b0;
        drain_inc  = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    load_cfg   = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                job_clr    = 1'b1;
                state_next = (len_q != '0) ? ISSUE : DRAIN;
            end
            ISSUE: begin
                issue = 1'b1;
                if (idx_q == len_q - ADDR_WIDTH'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Last product lands on mac_out MAC_LAT+1 cycles after the last read.
                if (drain_q == DRAIN_W'(MAC_LAT)) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    drain_inc = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode; reset masks control outputs in the same cycle it is asserted.
    always_comb begin
        start_ready = (state == IDLE) && !reset;
        busy        = (state != IDLE) && !reset;
        act_rd_en   = (state == ISSUE) && !reset;
        wgt_rd_en   = act_rd_en;
        act_rd_addr = act_base_q + idx_q;
        wgt_rd_addr = wgt_base_q + idx_q;
        mac_clr     = (state == CLEAR) || reset;
        mac_en      = mac_en_q && !reset;
        mac_act     = mac_en ? act_rd_data : 4'h0;
        mac_weight  = mac_en ? wgt_rd_data : 4'h0;
        res_valid   = (state == DONE) && !reset;
        res_data    = reset ? '0 : res_q;
    end

endmodule

// File: tb/tb_apot4_dot_seq.sv
// tb_apot4_dot_seq: directed vectors for apot4_dot_seq.
// The bench provides the buffers, a two-stage MAC and its own APoT4 decode.
module tb_apot4_dot_seq;

    localparam int unsigned AW   = 8;
    localparam int unsigned ACCW = 16;
    localparam int unsigned MLAT = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start_valid;
    logic                   start_ready;
    logic [AW-1:0]          cfg_len;
    logic [AW-1:0]          cfg_act_base;
    logic [AW-1:0]          cfg_wgt_base;
    logic                   act_rd_en;
    logic [AW-1:0]          act_rd_addr;
    logic [3:0]             act_rd_data = 4'h0;
    logic                   wgt_rd_en;
    logic [AW-1:0]          wgt_rd_addr;
    logic [3:0]             wgt_rd_data = 4'h0;
    logic                   mac_clr;
    logic                   mac_en;
    logic [3:0]             mac_act;
    logic [3:0]             mac_weight;
    logic signed [ACCW-1:0] mac_out;
    logic                   res_valid;
    logic                   res_ready;
    logic signed [ACCW-1:0] res_data;
    logic                   busy;

    always #5 clk = ~clk;

    apot4_dot_seq #(.ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .MAC_LAT(MLAT)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .cfg_len(cfg_len), .cfg_act_base(cfg_act_base), .cfg_wgt_base(cfg_wgt_base),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_act(mac_act), .mac_weight(mac_weight),
        .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    // Buffers: one-cycle read latency; junk (4'hA) is returned when not read.
    logic [3:0] act_mem [256];
    logic [3:0] wgt_mem [256];

    always @(posedge clk) begin
        act_rd_data <= act_rd_en ? act_mem[act_rd_addr] : 4'hA;
        wgt_rd_data <= wgt_rd_en ? wgt_mem[wgt_rd_addr] : 4'hA;
    end

    // APoT4 decode used by the MAC model: sign bit 3, magnitude level from bits 2:0.
    function automatic logic signed [15:0] apot(input logic [3:0] c);
        logic signed [15:0] m;
        case (c[2:0])
            3'd0: m = 16'sd0;
            3'd1: m = 16'sd1;
            3'd2: m = 16'sd2;
            3'd3: m = 16'sd10;
            3'd4: m = 16'sd16;
            3'd5: m = 16'sd4;
            3'd6: m = 16'sd8;
            default: m = 16'sd32;
        endcase
        return c[3] ? -m : m;
    endfunction

    // MAC model: product visible on mac_out MAC_LAT=2 cycles after mac_en.
    logic                   st_v = 1'b0;
    logic signed [ACCW-1:0] st_p = '0;
    logic signed [ACCW-1:0] acc  = '0;
    assign mac_out = acc;

    always @(posedge clk) begin
        if (mac_clr) begin
            st_v <= 1'b0;
            st_p <= '0;
            acc  <= '0;
        end else begin
            st_v <= mac_en;
            st_p <= mac_en ? apot(mac_act) * apot(mac_weight) : '0;
            if (st_v) acc <= acc + st_p;
        end
    end

    // Event monitor: cumulative counts and a log of activation addresses.
    int         rd_cnt    = 0;
    int         mac_cnt   = 0;
    int         clr_cnt   = 0;
    int         vld_cnt   = 0;
    int         bad_gate  = 0;
    int         bad_align = 0;
    logic       prev_rd   = 1'b0;
    logic [7:0] addr_log [1024];

    always @(posedge clk) begin
        if (act_rd_en) begin
            addr_log[rd_cnt % 1024] <= act_rd_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (mac_en)    mac_cnt <= mac_cnt + 1;
        if (mac_clr && !reset) clr_cnt <= clr_cnt + 1;
        if (res_valid) vld_cnt <= vld_cnt + 1;
        if (!mac_en && (mac_act != 4'h0 || mac_weight != 4'h0)) bad_gate <= bad_gate + 1;
        if (!reset && (mac_en != prev_rd || wgt_rd_en != act_rd_en)) bad_align <= bad_align + 1;
        prev_rd <= act_rd_en;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // One job: start handshake, wait for result, optionally hold res_ready low.
    task automatic run_job(input logic [7:0] len, input logic [7:0] ab, input logic [7:0] wb,
                           input int exp_res, input int hold);
        int rd0, mac0, clr0, cyc;
        @(negedge clk);
        rd0  = rd_cnt;
        mac0 = mac_cnt;
        clr0 = clr_cnt;
        cfg_len      = len;
        cfg_act_base = ab;
        cfg_wgt_base = wb;
        start_valid  = 1'b1;
        #1;
        check("start_ready", start_ready, 1);
        @(negedge clk);
        start_valid  = 1'b0;
        cfg_len      = 8'h55;
        cfg_act_base = 8'hC3;
        cfg_wgt_base = 8'h3C;
        cyc = 1;
        while (!res_valid && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, int'(len) + 5);
        check("res_data", res_data, exp_res);
        for (int k = 0; k < hold; k++) begin
            start_valid = (k % 3 == 1);
            #1;
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, exp_res);
            check("hold_start_ready", start_ready, 0);
            check("hold_busy", busy, 1);
            @(negedge clk);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("post_res_valid", res_valid, 0);
        check("post_start_ready", start_ready, 1);
        check("post_busy", busy, 0);
        check("rd_count", rd_cnt - rd0, int'(len));
        check("mac_count", mac_cnt - mac0, int'(len));
        check("clr_count", clr_cnt - clr0, 1);
    endtask

    typedef struct {
        logic [7:0] len;
        logic [7:0] ab;
        logic [7:0] wb;
        int         exp_res;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int rd0, vld0;
        logic [7:0] exp_addr [4];

        for (int a = 0; a < 256; a++) begin
            act_mem[a] = 4'h0;
            wgt_mem[a] = 4'h0;
        end
        act_mem[8'h10] = 4'h3; act_mem[8'h11] = 4'hB; act_mem[8'h12] = 4'h4;
        wgt_mem[8'h20] = 4'h3; wgt_mem[8'h21] = 4'h3; wgt_mem[8'h22] = 4'h2;
        act_mem[8'hFE] = 4'h1; act_mem[8'hFF] = 4'h2; act_mem[8'h00] = 4'h3; act_mem[8'h01] = 4'h9;
        wgt_mem[8'h30] = 4'h1; wgt_mem[8'h31] = 4'h1; wgt_mem[8'h32] = 4'h1; wgt_mem[8'h33] = 4'h1;
        act_mem[8'h40] = 4'h7; act_mem[8'h41] = 4'h6;
        wgt_mem[8'h40] = 4'h7; wgt_mem[8'h41] = 4'hF;
        act_mem[8'h50] = 4'h5; wgt_mem[8'h60] = 4'h3;

        vecs[0] = '{len: 8'd1,   ab: 8'h10, wb: 8'h20, exp_res: 100};
        vecs[1] = '{len: 8'd3,   ab: 8'h10, wb: 8'h20, exp_res: 32};
        vecs[2] = '{len: 8'd0,   ab: 8'h10, wb: 8'h20, exp_res: 0};
        vecs[3] = '{len: 8'd4,   ab: 8'hFE, wb: 8'h30, exp_res: 12};
        vecs[4] = '{len: 8'd2,   ab: 8'h40, wb: 8'h40, exp_res: 768};
        vecs[5] = '{len: 8'd255, ab: 8'h10, wb: 8'h20, exp_res: 72};
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;

        reset        = 1'b1;
        start_valid  = 1'b0;
        res_ready    = 1'b0;
        cfg_len      = '0;
        cfg_act_base = '0;
        cfg_wgt_base = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_rd_en", act_rd_en, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_clr", mac_clr, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_start_ready", start_ready, 0);
        reset = 1'b0;
        #1;
        check("rel_start_ready", start_ready, 1);
        check("rel_mac_clr", mac_clr, 0);

        // res_ready with no result pending does nothing.
        res_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready_res_valid", res_valid, 0);
            check("idle_ready_start_ready", start_ready, 1);
        end
        res_ready = 1'b0;

        // Table vectors.
        for (int v = 0; v < 6; v++) begin
            rd0 = rd_cnt;
            run_job(vecs[v].len, vecs[v].ab, vecs[v].wb, vecs[v].exp_res, 0);
            if (v == 3) begin
                for (int k = 0; k < 4; k++)
                    check("wrap_addr", addr_log[(rd0 + k) % 1024], exp_addr[k]);
            end
        end

        // Result held for 10 cycles while start_valid pulses.
        run_job(8'd1, 8'h10, 8'h20, 100, 10);

        // Reset in ISSUE at i=2 of a len=5 job.
        @(negedge clk);
        cfg_len      = 8'd5;
        cfg_act_base = 8'h10;
        cfg_wgt_base = 8'h20;
        start_valid  = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_rd_en", act_rd_en, 1);
        check("abort_pre_addr", act_rd_addr, 8'h12);
        vld0  = vld_cnt;
        reset = 1'b1;
        #1;
        check("abort_rd_en", act_rd_en, 0);
        check("abort_wgt_rd_en", wgt_rd_en, 0);
        check("abort_mac_en", mac_en, 0);
        check("abort_mac_clr", mac_clr, 1);
        check("abort_busy", busy, 0);
        check("abort_start_ready", start_ready, 0);
        repeat (2) @(negedge clk);
        check("abort_res_data", res_data, 0);
        reset = 1'b0;
        #1;
        check("abort_rel_start_ready", start_ready, 1);
        repeat (8) @(negedge clk);
        check("abort_no_result", vld_cnt - vld0, 0);
        check("abort_idle_busy", busy, 0);
        run_job(8'd3, 8'h10, 8'h20, 32, 0);

        check("mac_operand_gating", bad_gate, 0);
        check("mac_en_alignment", bad_align, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
